// File: rtl/smarthome_pkg.sv
// Shared types and default constants for the smart-home input conditioner.
package smarthome_pkg;

    // Per-channel debounce state
    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } db_state_t;

    // 1 ms at 50 MHz
    localparam int unsigned DEBOUNCE_CYCLES_DEF   = 50000;
    // 1 s at 50 MHz
    localparam int unsigned LONG_PRESS_CYCLES_DEF = 50000000;

endpackage

// File: rtl/smarthome_input_conditioner_debouncer.sv
// One conditioning channel: 2-FF synchroniser, 4-state debounce FSM with a
// qualification counter, registered level and a one-cycle rise pulse.
module input_debouncer
    import smarthome_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned CNT_W           = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic pulse
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             s;
    db_state_t        state;
    logic [CNT_W-1:0] cnt;

    assign s = sync_q[1];

    // Two-stage synchroniser for the asynchronous raw input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], raw};
        end
    end

    // Debounce FSM; level and pulse are registered alongside the state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= STABLE_LO;
            cnt   <= '0;
            level <= 1'b0;
            pulse <= 1'b0;
        end else begin
            pulse <= 1'b0;
            case (state)
                STABLE_LO: begin
                    if (s) begin
                        state <= WAIT_HI;
                        cnt   <= CNT_W'(1);
                    end
                end
                WAIT_HI: begin
                    if (!s) begin
                        state <= STABLE_LO;
                        cnt   <= '0;
                    end else if (cnt == LAST) begin
                        state <= STABLE_HI;
                        cnt   <= '0;
                        level <= 1'b1;
                        pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STABLE_HI: begin
                    if (!s) begin
                        state <= WAIT_LO;
                        cnt   <= CNT_W'(1);
                    end
                end
                WAIT_LO: begin
                    if (s) begin
                        state <= STABLE_HI;
                        cnt   <= '0;
                    end else if (cnt == LAST) begin
                        state <= STABLE_LO;
                        cnt   <= '0;
                        level <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= STABLE_LO;
                    cnt   <= '0;
                    level <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/smarthome_input_conditioner.sv
// Input conditioner for the smart-home LED channel: debounces push-button,
// ESP command and mode switch, and emits press / long-press pulses.
// Optional feature macro: LONG_PRESS_DETECT_EN (long-press counter and
// LONG_PRESS_OUT); when undefined LONG_PRESS_OUT is tied low.
module smarthome_input_conditioner
    import smarthome_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned CNT_W             = 16,
    parameter int unsigned LONG_PRESS_CYCLES = LONG_PRESS_CYCLES_DEF,
    parameter int unsigned LONG_W            = 26
) (
    input  logic CLK_IN,
    input  logic CLR_FF,
    input  logic PB_RAW_IN,
    input  logic ESP_RAW_IN,
    input  logic SW_MODE_RAW_IN,
    output logic PB_LEVEL_OUT,
    output logic PB_PULSE_OUT,
    output logic ESP_OUT,
    output logic SW_MODE_OUT,
    output logic LONG_PRESS_OUT
);

    logic esp_pulse_unused;
    logic sw_pulse_unused;

    input_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_pb (
        .clk   (CLK_IN),
        .rst   (CLR_FF),
        .raw   (PB_RAW_IN),
        .level (PB_LEVEL_OUT),
        .pulse (PB_PULSE_OUT)
    );

    input_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_esp (
        .clk   (CLK_IN),
        .rst   (CLR_FF),
        .raw   (ESP_RAW_IN),
        .level (ESP_OUT),
        .pulse (esp_pulse_unused)
    );

    input_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_sw (
        .clk   (CLK_IN),
        .rst   (CLR_FF),
        .raw   (SW_MODE_RAW_IN),
        .level (SW_MODE_OUT),
        .pulse (sw_pulse_unused)
    );

`ifdef LONG_PRESS_DETECT_EN
    localparam logic [LONG_W-1:0] LONG_TARGET = LONG_W'(LONG_PRESS_CYCLES);
    localparam logic [LONG_W-1:0] LONG_PRE    = LONG_W'(LONG_PRESS_CYCLES - 1);

    logic [LONG_W-1:0] long_cnt;

    // Count debounced-high cycles; pulse once on reaching the target, then hold
    always_ff @(posedge CLK_IN or posedge CLR_FF) begin
        if (CLR_FF) begin
            long_cnt       <= '0;
            LONG_PRESS_OUT <= 1'b0;
        end else begin
            LONG_PRESS_OUT <= 1'b0;
            if (!PB_LEVEL_OUT) begin
                long_cnt <= '0;
            end else if (long_cnt != LONG_TARGET) begin
                long_cnt <= long_cnt + 1'b1;
                if (long_cnt == LONG_PRE) begin
                    LONG_PRESS_OUT <= 1'b1;
                end
            end
        end
    end
`else
    localparam int unsigned long_cfg_unused = LONG_PRESS_CYCLES + LONG_W;

    assign LONG_PRESS_OUT = 1'b0;
`endif

endmodule

// File: tb/tb_smarthome_input_conditioner.sv
// Self-checking bench for smarthome_input_conditioner (DEBOUNCE_CYCLES=4,
// LONG_PRESS_CYCLES=20): directed scenarios plus randomized input traffic,
// checked every cycle against a history-window reference model.
module tb_smarthome_input_conditioner;

    localparam int D = 4;
    localparam int L = 20;
`ifdef LONG_PRESS_DETECT_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pb  = 1'b0;
    logic esp = 1'b0;
    logic sw  = 1'b0;
    logic pb_level, pb_pulse, esp_out, sw_out, long_out;

    always #5 clk = ~clk;

    smarthome_input_conditioner #(
        .DEBOUNCE_CYCLES   (D),
        .CNT_W             (4),
        .LONG_PRESS_CYCLES (L),
        .LONG_W            (6)
    ) dut (
        .CLK_IN         (clk),
        .CLR_FF         (rst),
        .PB_RAW_IN      (pb),
        .ESP_RAW_IN     (esp),
        .SW_MODE_RAW_IN (sw),
        .PB_LEVEL_OUT   (pb_level),
        .PB_PULSE_OUT   (pb_pulse),
        .ESP_OUT        (esp_out),
        .SW_MODE_OUT    (sw_out),
        .LONG_PRESS_OUT (long_out)
    );

    int errors = 0;
    int checks = 0;
    int pulse_seen = 0;
    int long_seen = 0;

    // Reference model: a channel's level flips once the last D synchronised
    // samples all disagree with it; synchroniser is a plain 2-deep delay.
    bit       ms1 [3];
    bit       ms2 [3];
    bit [7:0] hist [3];
    bit       lvl [3];
    int       hi_cycles;
    bit       e_pulse;
    bit       e_long;

    function automatic bit raw_of(input int ch);
        return (ch == 0) ? pb : (ch == 1) ? esp : sw;
    endfunction

    function automatic bit out_of(input int ch);
        return (ch == 0) ? pb_level : (ch == 1) ? esp_out : sw_out;
    endfunction

    task automatic model_reset();
        for (int ch = 0; ch < 3; ch++) begin
            ms1[ch] = 0; ms2[ch] = 0; hist[ch] = '0; lvl[ch] = 0;
        end
        hi_cycles = 0; e_pulse = 0; e_long = 0;
    endtask

    task automatic model_edge();
        bit       prev_pb;
        bit       s;
        bit [7:0] mask;
        mask    = 8'((1 << D) - 1);
        prev_pb = lvl[0];
        e_pulse = 0;
        e_long  = 0;
        for (int ch = 0; ch < 3; ch++) begin
            s        = ms2[ch];
            ms2[ch]  = ms1[ch];
            ms1[ch]  = raw_of(ch);
            hist[ch] = {hist[ch][6:0], s};
            if (!lvl[ch] && ((hist[ch] & mask) == mask)) lvl[ch] = 1;
            else if (lvl[ch] && ((hist[ch] & mask) == 8'h00)) lvl[ch] = 0;
        end
        if (lvl[0] && !prev_pb) e_pulse = 1;
        if (prev_pb) begin
            hi_cycles++;
            e_long = LONG_EN && (hi_cycles == L);
        end else begin
            hi_cycles = 0;
        end
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("pb_level", pb_level, lvl[0]);
        chk("pb_pulse", pb_pulse, e_pulse);
        chk("esp_out",  esp_out,  lvl[1]);
        chk("sw_out",   sw_out,   lvl[2]);
        chk("long_press", long_out, e_long);
    endtask

    // One clock: advance the model on the edge, sample DUT 1 time unit later
    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_edge();
        #1;
        check_all();
        if (pb_pulse) pulse_seen++;
        if (long_out) long_seen++;
    endtask

    // Assert reset between edges and confirm outputs clear without a clock
    task automatic async_reset();
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
    endtask

    task automatic wait_out(input int ch, input bit val, output int n);
        n = -1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (out_of(ch) == val) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_pulse(output int n);
        n = -1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (pb_pulse) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int n;
        int long_at;
        model_reset();

        // Reset held: outputs stay 0
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) tick();

        // Clean press, held long enough for a long press
        pulse_seen = 0; long_seen = 0;
        pb = 1'b1;
        wait_out(0, 1'b1, n);
        chk_int("press_latency", n, D + 2);
        chk_int("press_pulse_same_cycle", int'(pb_pulse), 1);
        long_at = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (long_out && long_at < 0) long_at = i;
        end
        chk_int("press_pulse_count", pulse_seen, 1);
        chk_int("long_press_delay", long_at, LONG_EN ? L : -1);
        chk_int("long_press_count", long_seen, LONG_EN ? 1 : 0);

        // Release: level falls after D+2 cycles with no pulse
        pulse_seen = 0;
        pb = 1'b0;
        wait_out(0, 1'b0, n);
        chk_int("release_latency", n, D + 2);
        for (int i = 0; i < 5; i++) tick();
        chk_int("release_pulse_count", pulse_seen, 0);

        // Bounce 1,0,1,0 then hold 1: one pulse D+2 after the final rise
        pulse_seen = 0;
        pb = 1'b1; tick();
        pb = 1'b0; tick();
        pb = 1'b1; tick();
        pb = 1'b0; tick();
        pb = 1'b1;
        wait_pulse(n);
        chk_int("bounce_latency", n, D + 2);
        for (int i = 0; i < 6; i++) tick();
        chk_int("bounce_pulse_count", pulse_seen, 1);
        pb = 1'b0;
        for (int i = 0; i < 10; i++) tick();

        // 3-cycle glitch alone is filtered
        pulse_seen = 0;
        pb = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        pb = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (pb_level) n++;
        end
        chk_int("glitch_level_cycles", n, 0);
        chk_int("glitch_pulse_count", pulse_seen, 0);

        // Asynchronous reset while the button level is high
        pb = 1'b1; esp = 1'b1;
        wait_out(0, 1'b1, n);
        for (int i = 0; i < 2; i++) tick();
        async_reset();
        for (int i = 0; i < 3; i++) tick();
        pb = 1'b0; esp = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) tick();

        // Reset mid-debounce, button held through release; ESP/SW in parallel
        pulse_seen = 0;
        pb = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        async_reset();
        for (int i = 0; i < 2; i++) tick();
        chk_int("abort_pulse_count", pulse_seen, 0);
        esp = 1'b1; sw = 1'b1;
        rst = 1'b0;
        wait_pulse(n);
        chk_int("held_through_reset_latency", n, D + 2);
        chk_int("esp_parallel", int'(esp_out), 1);
        chk_int("sw_parallel", int'(sw_out), 1);
        pb = 1'b0; esp = 1'b0; sw = 1'b0;
        for (int i = 0; i < 8; i++) tick();

        // Randomized traffic with sparse toggles and rare resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) pb  = ~pb;
            if ($urandom_range(0, 5) == 0) esp = ~esp;
            if ($urandom_range(0, 5) == 0) sw  = ~sw;
            if ($urandom_range(0, 9) == 0) pb = 1'b1;
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;
        pb = 1'b1;
        for (int i = 0; i < 40; i++) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/smarthome_input_conditioner.md
# smarthome_input_conditioner

Front-end conditioning stage for the smart-home LED channel. It synchronises and debounces the raw push-button, ESP command and mode-switch inputs. It emits clean levels plus a single-cycle press pulse that directly drives the LED toggle stage's PB/ESP/SW_MODE inputs. Without this stage, contact bounce would toggle the LED flip-flop several times per press.

## Interface
- DEBOUNCE_CYCLES, default 50000: consecutive stable cycles required before a debounced level changes (1 ms at 50 MHz); legal range 2..65535.
- CNT_W, default 16: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- LONG_PRESS_CYCLES, default 50000000: debounced-high cycles that qualify a long press.
- LONG_W, default 26: long-press counter width; must satisfy 2^LONG_W > LONG_PRESS_CYCLES.
- CLK_IN  in  1  system clock; all logic on its rising edge.
- CLR_FF  in  1  asynchronous, active-high reset.
- PB_RAW_IN  in  1  raw push-button, asynchronous, bouncing.
- ESP_RAW_IN  in  1  raw ESP GPIO command level, asynchronous.
- SW_MODE_RAW_IN  in  1  raw slide switch (1 = manual PB mode, 0 = ESP mode).
- PB_LEVEL_OUT  out  1  debounced button level.
- PB_PULSE_OUT  out  1  one-cycle pulse on each debounced button press (0→1).
- ESP_OUT  out  1  debounced ESP level.
- SW_MODE_OUT  out  1  debounced mode switch.
- LONG_PRESS_OUT  out  1  one-cycle pulse when a press reaches LONG_PRESS_CYCLES.

## Operation
- Each raw input passes through a 2-FF synchroniser. The second-stage output is the channel's sampled value `s`.
- Each channel has a 4-state debounce FSM: STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO. Each channel also has a counter `cnt`.
  - STABLE_LO with s=1 → WAIT_HI, cnt=1.
  - WAIT_HI with s=1 and cnt<DEBOUNCE_CYCLES-1 → cnt+1.
  - WAIT_HI with s=1 and cnt==DEBOUNCE_CYCLES-1 → STABLE_HI, level=1.
  - WAIT_HI with s=0 → STABLE_LO, cnt=0. Any glitch restarts qualification.
  - STABLE_HI, WAIT_LO: mirror image of the above.
- Debounced level is 1 in STABLE_HI and WAIT_LO, and 0 otherwise.
- PB_PULSE_OUT is asserted for exactly one cycle: the cycle in which the PB channel enters STABLE_HI. Release produces no pulse.
- Long press:
  - A counter runs while PB is in STABLE_HI or WAIT_LO.
  - On reaching LONG_PRESS_CYCLES it asserts LONG_PRESS_OUT for one cycle, then saturates. There is at most one pulse per press.
  - The counter clears when PB enters STABLE_LO.
- The counter never wraps: saturation or transition occurs before 2^CNT_W.

## Timing
- Reset values: all outputs 0, synchroniser FFs 0, all FSMs STABLE_LO, all counters 0.
- Latency from raw edge to level change is 2 synchroniser cycles plus DEBOUNCE_CYCLES cycles. PB_PULSE_OUT asserts in the same cycle as the PB_LEVEL_OUT rise.
- A raw pulse shorter than DEBOUNCE_CYCLES cycles produces no output change.
- Reset asserted mid-qualification aborts it: the channel returns to STABLE_LO and no pulse is emitted.
- Button held through reset release: this is treated as a new press. PB_PULSE_OUT fires 2+DEBOUNCE_CYCLES cycles after release.
- The three channels are independent. Simultaneous edges on all inputs complete in the same cycle.

## Configuration
- LONG_PRESS_DETECT_EN defined: the long-press counter and LONG_PRESS_OUT logic are built as described.
- LONG_PRESS_DETECT_EN undefined:
  - The counter is not synthesised.
  - LONG_PRESS_OUT is tied to 0.
  - The port list is unchanged.

## Structure
- Shared package `smarthome_pkg` holds:
  - the debounce state enum (STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO);
  - default constants for DEBOUNCE_CYCLES and LONG_PRESS_CYCLES.
- Sub-module `input_debouncer` contains one synchroniser, one FSM, one counter and a rise-pulse output. It is instantiated three times. The top level adds the long-press logic.

## Test plan
Run with DEBOUNCE_CYCLES=4 and LONG_PRESS_CYCLES=20.
- Reset: assert CLR_FF asynchronously between edges → all outputs 0 immediately; they stay 0 while held.
- Clean press: PB_RAW_IN 0→1 held → PB_LEVEL_OUT=1 exactly 6 cycles later. PB_PULSE_OUT=1 for that single cycle only.
- Bounce: PB_RAW_IN toggles 1,0,1,0 on successive cycles, then holds 1 → exactly one PB_PULSE_OUT, 6 cycles after the final rise. A 3-cycle glitch alone produces nothing.
- Release: from held, PB_RAW_IN→0 → PB_LEVEL_OUT=0 after 6 cycles, with no pulse.
- Long press: hold PB_RAW_IN for 40 cycles → LONG_PRESS_OUT pulses once, 20 cycles after PB_LEVEL_OUT rose. With the macro undefined it stays 0.
- Reset mid-debounce: raise PB_RAW_IN, assert CLR_FF at cycle 3, release it with PB still 1 → PB_PULSE_OUT 6 cycles after release. ESP_OUT and SW_MODE_OUT debounce independently in parallel.
